l2_bank_xbar: RTL

- Parametrised request/response crossbar between NUM_L1_PORTS L1 clients and NUM_BANKS independent L2 banks, plus the shared memory-side arbiter.
- Adds three things: per-bank round-robin arbitration with backpressure to colliding ports, response routing by port-ID tracking, and memory responses steered to the issuing bank through a tag FIFO instead of being broadcast.
- Sits between the L1 caches and the array of l2_bank_multiport instances.

---
 rtl/l2_bank_xbar_pkg.sv | 25 ++
 rtl/l2_bank_xbar_arb.sv | 38 +++
 rtl/l2_bank_xbar.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/l2_bank_xbar_pkg.sv
// Shared types and widths for the L2 bank crossbar.
package l2_bank_xbar_pkg;
  localparam int BLK_SIZE     = 128;
  localparam int ADDR_W       = 32;
  localparam int NUM_L1_PORTS = 2;
  localparam int NUM_BANKS    = 4;
  localparam int XBAR_PORT_W  = (NUM_L1_PORTS > 1) ? $clog2(NUM_L1_PORTS) : 1;
  localparam int XBAR_BANK_W  = $clog2(NUM_BANKS);

  typedef logic [XBAR_PORT_W-1:0] xbar_port_id_t;
  typedef logic [XBAR_BANK_W-1:0] xbar_bank_id_t;

  typedef struct packed {
    logic                valid;
    logic                we;
    logic [ADDR_W-1:0]   addr;
    logic [BLK_SIZE-1:0] data;
  } lowX_req_t;

  typedef struct packed {
    logic                valid;
    logic                ready;
    logic [BLK_SIZE-1:0] data;
  } lowX_res_t;
endpackage

// File: rtl/l2_bank_xbar_arb.sv
// Round-robin arbiter: one-hot grant starting at the pointer; the pointer
// moves to winner+1 only when the caller signals that the grant was taken.
module xbar_rr_arb #(
  parameter int N = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [N-1:0] req_i,
  input  logic         acc_i,
  output logic [N-1:0] gnt_o
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d, win;
  logic          found;

  // first requester at or after the pointer, circularly
  always_comb begin
    gnt_o = '0;
    win   = ptr_q;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && req_i[(int'(ptr_q) + k) % N]) begin
        found = 1'b1;
        gnt_o[(int'(ptr_q) + k) % N] = 1'b1;
        win = PW'((int'(ptr_q) + k) % N);
      end
    end
    ptr_d = ptr_q;
    if (acc_i && found) ptr_d = (win == PW'(N - 1)) ? '0 : win + 1'b1;
  end

  // pointer register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end
endmodule

// File: rtl/l2_bank_xbar.sv
// L1 <-> L2 bank crossbar with per-bank RR arbitration, port-ID response
// routing and tag-steered memory responses.
// Optional: XBAR_PORT_ORDER_EN keeps responses per port in request order.
// OUTST_DEPTH and MEM_OUTST must be powers of two >= 2.
module l2_bank_xbar
  import l2_bank_xbar_pkg::*;
#(
  parameter int NUM_L1_PORTS = 2,
  parameter int NUM_BANKS    = 4,
  parameter int OUTST_DEPTH  = 4,
  parameter int MEM_OUTST    = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  lowX_req_t [NUM_L1_PORTS-1:0] l1_req_i,
  output lowX_res_t [NUM_L1_PORTS-1:0] l1_res_o,
  output lowX_req_t [NUM_BANKS-1:0]    bank_req_o,
  input  lowX_res_t [NUM_BANKS-1:0]    bank_res_i,
  output logic      [NUM_BANKS-1:0]    bank_res_ready_o,
  output lowX_req_t                    mem_req_o,
  input  lowX_res_t                    mem_res_i,
  input  lowX_req_t [NUM_BANKS-1:0]    bank_mem_req_i,
  output lowX_res_t [NUM_BANKS-1:0]    bank_mem_res_o
);
  localparam int PW      = (NUM_L1_PORTS > 1) ? $clog2(NUM_L1_PORTS) : 1;
  localparam int BW      = $clog2(NUM_BANKS);
  localparam int TW      = $clog2(OUTST_DEPTH);
  localparam int MW      = $clog2(MEM_OUTST);
  localparam int BOFFSET = $clog2(BLK_SIZE / 8);

  logic [NUM_BANKS-1:0][NUM_L1_PORTS-1:0] breq, bgnt;
  logic [NUM_L1_PORTS-1:0][NUM_BANKS-1:0] rreq, rgnt;
  logic [NUM_BANKS-1:0]                   bcan, bacc, tpop, tfull, tempty;
  logic [NUM_BANKS-1:0][PW-1:0]           twin, thead;
  logic [NUM_L1_PORTS-1:0]                prdy, racc, pstall;

  logic [NUM_BANKS-1:0][OUTST_DEPTH-1:0][PW-1:0] trk_q;
  logic [NUM_BANKS-1:0][TW:0]                    twp_q, trp_q;

  logic [NUM_BANKS-1:0]           mreq, mgnt;
  logic                           mcan, macc, mpop, mfull, mempty;
  logic [BW-1:0]                  mwin;
  logic [MEM_OUTST-1:0][BW-1:0]   tag_q;
  logic [MW:0]                    mwp_q, mrp_q;

  function automatic logic [BW-1:0] bank_of(input logic [ADDR_W-1:0] a);
    return a[BOFFSET +: BW];
  endfunction

  // per-bank tracker status
  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      tempty[b] = (twp_q[b] == trp_q[b]);
      tfull[b]  = (twp_q[b][TW] != trp_q[b][TW]) && (twp_q[b][TW-1:0] == trp_q[b][TW-1:0]);
      thead[b]  = trk_q[b][trp_q[b][TW-1:0]];
    end
  end

  // request path: route valid ports to their bank, grant only if the bank can take it
  always_comb begin
    breq       = '0;
    bank_req_o = '0;
    twin       = '0;
    prdy       = '0;
    for (int p = 0; p < NUM_L1_PORTS; p++)
      for (int b = 0; b < NUM_BANKS; b++)
        if (l1_req_i[p].valid && !pstall[p] && bank_of(l1_req_i[p].addr) == BW'(b))
          breq[b][p] = 1'b1;
    for (int b = 0; b < NUM_BANKS; b++) begin
      bcan[b] = rst_ni && bank_res_i[b].ready && !tfull[b];
      bacc[b] = bcan[b] && (|breq[b]);
      for (int p = 0; p < NUM_L1_PORTS; p++)
        if (bgnt[b][p] && bcan[b]) begin
          bank_req_o[b] = l1_req_i[p];
          twin[b]       = PW'(p);
          prdy[p]       = 1'b1;
        end
    end
  end

`ifdef XBAR_PORT_ORDER_EN
  logic [NUM_L1_PORTS-1:0][OUTST_DEPTH-1:0][BW-1:0] pof_q;
  logic [NUM_L1_PORTS-1:0][TW:0]                    pwp_q, prp_q;
  logic [NUM_L1_PORTS-1:0][BW-1:0]                  pof_head;
  logic [NUM_L1_PORTS-1:0]                          pof_empty;

  // per-port order FIFO status; a full FIFO stalls new accepts from that port
  always_comb begin
    for (int p = 0; p < NUM_L1_PORTS; p++) begin
      pof_empty[p] = (pwp_q[p] == prp_q[p]);
      pstall[p]    = (pwp_q[p][TW] != prp_q[p][TW]) && (pwp_q[p][TW-1:0] == prp_q[p][TW-1:0]);
      pof_head[p]  = pof_q[p][prp_q[p][TW-1:0]];
    end
  end

  // record bank IDs in accept order, retire on delivery
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pof_q <= '0;
      pwp_q <= '0;
      prp_q <= '0;
    end else begin
      for (int p = 0; p < NUM_L1_PORTS; p++) begin
        if (prdy[p]) begin
          pof_q[p][pwp_q[p][TW-1:0]] <= bank_of(l1_req_i[p].addr);
          pwp_q[p] <= pwp_q[p] + 1'b1;
        end
        if (racc[p]) prp_q[p] <= prp_q[p] + 1'b1;
      end
    end
  end
`else
  assign pstall = '0;
`endif

  // response path: each bank's head port ID picks the destination port
  always_comb begin
    rreq             = '0;
    l1_res_o         = '0;
    bank_res_ready_o = '0;
    tpop             = '0;
    for (int b = 0; b < NUM_BANKS; b++)
      for (int p = 0; p < NUM_L1_PORTS; p++)
        if (bank_res_i[b].valid && !tempty[b] && thead[b] == PW'(p)
`ifdef XBAR_PORT_ORDER_EN
            && !pof_empty[p] && pof_head[p] == BW'(b)
`endif
           )
          rreq[p][b] = 1'b1;
    for (int p = 0; p < NUM_L1_PORTS; p++) begin
      racc[p]           = |rreq[p];
      l1_res_o[p].ready = prdy[p];
      for (int b = 0; b < NUM_BANKS; b++)
        if (rgnt[p][b]) begin
          l1_res_o[p].valid   = 1'b1;
          l1_res_o[p].data    = bank_res_i[b].data;
          bank_res_ready_o[b] = 1'b1;
          tpop[b]             = 1'b1;
        end
    end
    // orphan responses (nothing outstanding) are consumed and dropped
    for (int b = 0; b < NUM_BANKS; b++)
      if (rst_ni && bank_res_i[b].valid && tempty[b]) bank_res_ready_o[b] = 1'b1;
  end

  // per-bank port-ID trackers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      trk_q <= '0;
      twp_q <= '0;
      trp_q <= '0;
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (bacc[b]) begin
          trk_q[b][twp_q[b][TW-1:0]] <= twin[b];
          twp_q[b] <= twp_q[b] + 1'b1;
        end
        if (tpop[b]) trp_q[b] <= trp_q[b] + 1'b1;
      end
    end
  end

  // memory path: RR over bank misses, tag FIFO steers the response back
  always_comb begin
    mempty    = (mwp_q == mrp_q);
    mfull     = (mwp_q[MW] != mrp_q[MW]) && (mwp_q[MW-1:0] == mrp_q[MW-1:0]);
    mcan      = rst_ni && mem_res_i.ready && !mfull;
    mpop      = mem_res_i.valid && !mempty;
    mem_req_o = '0;
    mwin      = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      mreq[b] = bank_mem_req_i[b].valid;
      if (mgnt[b] && mcan) begin
        mem_req_o = bank_mem_req_i[b];
        mwin      = BW'(b);
      end
    end
    macc = mcan && (|mreq);
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_mem_res_o[b]       = '0;
      bank_mem_res_o[b].ready = mem_res_i.ready;
      if (mpop && tag_q[mrp_q[MW-1:0]] == BW'(b)) bank_mem_res_o[b] = mem_res_i;
    end
  end

  // memory tag FIFO
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tag_q <= '0;
      mwp_q <= '0;
      mrp_q <= '0;
    end else begin
      if (macc) begin
        tag_q[mwp_q[MW-1:0]] <= mwin;
        mwp_q <= mwp_q + 1'b1;
      end
      if (mpop) mrp_q <= mrp_q + 1'b1;
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    xbar_rr_arb #(.N(NUM_L1_PORTS)) u_arb (
      .clk_i(clk_i), .rst_ni(rst_ni), .req_i(breq[b]), .acc_i(bacc[b]), .gnt_o(bgnt[b]));
    // a response arriving with nothing outstanding is a protocol error
    a_orphan: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(bank_res_i[b].valid && tempty[b]));
  end

  for (genvar p = 0; p < NUM_L1_PORTS; p++) begin : g_port
    xbar_rr_arb #(.N(NUM_BANKS)) u_arb (
      .clk_i(clk_i), .rst_ni(rst_ni), .req_i(rreq[p]), .acc_i(racc[p]), .gnt_o(rgnt[p]));
  end

  xbar_rr_arb #(.N(NUM_BANKS)) u_mem_arb (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(mreq), .acc_i(macc), .gnt_o(mgnt));
endmodule
